// File: rtl/delay_tap_pkg.sv
// Shared types and constants for the delay-line tap controller.
// Holds the state encoding, tap depths and the sel-to-depth lookup.
package delay_tap_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 7;

  localparam int TAP0 = 30;
  localparam int TAP1 = 45;
  localparam int TAP2 = 60;
  localparam int TAP3 = 90;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR,
    ST_FILL  = S_FILL,
    ST_RUN   = S_RUN
  } state_t;

  function automatic logic [CNT_W-1:0] tap_depth(input logic [1:0] sel);
    case (sel)
      2'd0:    tap_depth = CNT_W'(TAP0);
      2'd1:    tap_depth = CNT_W'(TAP1);
      2'd2:    tap_depth = CNT_W'(TAP2);
      2'd3:    tap_depth = CNT_W'(TAP3);
      default: tap_depth = CNT_W'(TAP0);
    endcase
  endfunction

endpackage

// File: rtl/tap_fill_counter.sv
// Saturating refill-shift counter: sync clear, increment enable,
// done flags that the count has reached the selected tap depth.
module tap_fill_counter
  import delay_tap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // count shifts since the last clear, never passing the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && !done) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r == limit);

endmodule

// File: rtl/delay_tap_controller.sv
// Tap-change sequencer for the 30/45/60/90-stage delay-line bank.
// Build option DLY_CTRL_HOLD_EN: out_data holds its last value through CLEAR/FILL.
module delay_tap_controller
  import delay_tap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_sel,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              line_shift,
  output logic              line_clr,
  output logic [1:0]        tap_sel,
  input  logic [DATA_W-1:0] tap_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fill_cnt
);

  state_t            state_r;
  logic [1:0]        tap_sel_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              pend_r;

  logic [CNT_W-1:0]  depth_s;
  logic [CNT_W-1:0]  fill_cnt_s;
  logic              done_s;
  logic              cfg_ready_s;
  logic              accept_s;
  logic              line_shift_s;
  logic              fill_inc_s;
  logic              fill_clr_s;
  logic              last_shift_s;

  assign depth_s      = tap_depth(tap_sel_r);
  assign cfg_ready_s  = ena && (state_r != ST_CLEAR);
  assign accept_s     = cfg_valid && cfg_ready_s;
  // an accepted request takes the cycle, so a coincident sample is dropped
  assign line_shift_s = ena && in_valid && !accept_s &&
                        ((state_r == ST_FILL) || (state_r == ST_RUN));
  assign fill_inc_s   = line_shift_s && (state_r == ST_FILL);
  assign fill_clr_s   = ena && (state_r == ST_CLEAR);
  assign last_shift_s = fill_inc_s && (fill_cnt_s == (depth_s - 7'd1));

  tap_fill_counter u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fill_clr_s),
    .inc   (fill_inc_s),
    .limit (depth_s),
    .count (fill_cnt_s),
    .done  (done_s)
  );

  // sequencer state plus the registered output stage; the sample from a shift
  // is taken from the tap on the following edge, once the bank has moved
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      tap_sel_r   <= 2'd0;
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      pend_r      <= 1'b0;
    end else if (!ena) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      state_r     <= ST_CLEAR;
      tap_sel_r   <= cfg_sel;
      busy_r      <= 1'b1;
      pend_r      <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef DLY_CTRL_HOLD_EN
      out_data_r  <= out_data_r;
`else
      out_data_r  <= {DATA_W{1'b0}};
`endif
    end else begin
      out_valid_r <= pend_r;
      if (pend_r) begin
        out_data_r <= tap_data;
      end else begin
        out_data_r <= out_data_r;
      end
      pend_r <= line_shift_s && ((state_r == ST_RUN) || last_shift_s);
      case (state_r)
        ST_CLEAR: begin
          state_r <= ST_FILL;
          busy_r  <= 1'b1;
        end
        ST_FILL: begin
          if (last_shift_s || done_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_FILL;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_s;
  assign line_shift = line_shift_s;
  assign line_clr   = fill_clr_s;
  assign tap_sel    = tap_sel_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign fill_cnt   = fill_cnt_s;

endmodule

// File: tb/tb_delay_tap_controller.sv
// Bench for delay_tap_controller: models the delay-line bank around the DUT and
// predicts outputs from the sample history since the last clear.
module tb_delay_tap_controller;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cfg_valid;
  logic [1:0] cfg_sel;
  logic       cfg_ready;
  logic       in_valid;
  logic       line_shift;
  logic       line_clr;
  logic [1:0] tap_sel;
  logic [7:0] tap_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic [6:0] fill_cnt;
  logic [7:0] in_data;

  logic [7:0] bank [0:127];

  int n_err = 0;
  int n_chk = 0;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_FILL  = 2;
  localparam int M_RUN   = 3;

  int         m_mode;
  logic [1:0] m_sel;
  int         m_fill;
  logic [7:0] m_out;
  logic       m_ov;
  logic       m_pend;
  logic [7:0] m_pval;
  logic [7:0] m_hist [$];

  logic pre_ready, pre_shift, pre_clr;

  typedef struct {
    logic       r, e, cv;
    logic [1:0] cs;
    logic       iv;
    logic       x_ready, x_shift, x_clr, x_busy;
    logic [1:0] x_tap;
    logic [6:0] x_fill;
    logic       x_ov;
  } vec_t;

  vec_t vecs [5];

  function automatic int depth_of(input logic [1:0] s);
    case (s)
      2'd0:    return 30;
      2'd1:    return 45;
      2'd2:    return 60;
      default: return 90;
    endcase
  endfunction

  delay_tap_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_valid  (cfg_valid),
    .cfg_sel    (cfg_sel),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .line_shift (line_shift),
    .line_clr   (line_clr),
    .tap_sel    (tap_sel),
    .tap_data   (tap_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .fill_cnt   (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tap_data = bank[depth_of(tap_sel) - 1];

  // delay-line bank driven by the DUT's clear/shift controls
  always @(posedge clk) begin
    if (!rst_n || line_clr) begin
      for (int i = 0; i < 128; i++) bank[i] <= 8'd0;
    end else if (line_shift) begin
      for (int i = 127; i > 0; i--) bank[i] <= bank[i-1];
      bank[0] <= in_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic cv, input logic [1:0] cs,
                      input logic iv, input logic [7:0] d);
    logic p_ready, p_acc, p_shift, p_clr;
    int   old;
    int   dep;
    rst_n = r; ena = e; cfg_valid = cv; cfg_sel = cs; in_valid = iv; in_data = d;
    #1;
    p_ready = e && (m_mode != M_CLEAR);
    p_acc   = cv && p_ready;
    p_shift = e && iv && !p_acc && (m_mode == M_FILL || m_mode == M_RUN);
    p_clr   = e && (m_mode == M_CLEAR);
    pre_ready = cfg_ready; pre_shift = line_shift; pre_clr = line_clr;
    chk("cfg_ready", 32'(cfg_ready), 32'(p_ready));
    chk("line_shift", 32'(line_shift), 32'(p_shift));
    chk("line_clr", 32'(line_clr), 32'(p_clr));
    @(posedge clk);
    old = m_mode;
    dep = depth_of(m_sel);
    if (!r) begin
      m_mode = M_IDLE; m_sel = 2'd0; m_fill = 0; m_out = 8'd0;
      m_ov = 1'b0; m_pend = 1'b0; m_hist.delete();
    end else if (!e) begin
      m_ov = 1'b0;
    end else if (p_acc) begin
      m_mode = M_CLEAR; m_sel = cs; m_pend = 1'b0; m_ov = 1'b0;
`ifndef DLY_CTRL_HOLD_EN
      m_out = 8'd0;
`endif
    end else begin
      m_ov = m_pend;
      if (m_pend) m_out = m_pval;
      m_pend = 1'b0;
      if (p_shift) begin
        m_hist.push_back(d);
        if (m_hist.size() > 128) void'(m_hist.pop_front());
        if (old == M_FILL) m_fill++;
        // a full line yields the sample that entered depth shifts ago
        if (old == M_RUN || (old == M_FILL && m_fill == dep)) begin
          m_pend = 1'b1;
          m_pval = m_hist[m_hist.size() - dep];
        end
        if (old == M_FILL && m_fill == dep) m_mode = M_RUN;
      end
      if (old == M_CLEAR) begin
        m_mode = M_FILL; m_fill = 0; m_hist.delete();
      end
    end
    @(negedge clk);
    chk("tap_sel", 32'(tap_sel), 32'(m_sel));
    chk("fill_cnt", 32'(fill_cnt), 32'(m_fill));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_out));
    chk("busy", 32'(busy), 32'(m_mode == M_CLEAR || m_mode == M_FILL));
  endtask

  initial begin
    int first;
    logic [7:0] first_val;
    logic [7:0] held;

    vecs[0] = '{r:1'b0, e:1'b1, cv:1'b1, cs:2'd3, iv:1'b1, x_ready:1'b1, x_shift:1'b0,
                x_clr:1'b0, x_busy:1'b0, x_tap:2'd0, x_fill:7'd0, x_ov:1'b0};
    vecs[1] = '{r:1'b1, e:1'b1, cv:1'b1, cs:2'd0, iv:1'b1, x_ready:1'b1, x_shift:1'b0,
                x_clr:1'b0, x_busy:1'b1, x_tap:2'd0, x_fill:7'd0, x_ov:1'b0};
    vecs[2] = '{r:1'b1, e:1'b1, cv:1'b1, cs:2'd2, iv:1'b1, x_ready:1'b0, x_shift:1'b0,
                x_clr:1'b1, x_busy:1'b1, x_tap:2'd0, x_fill:7'd0, x_ov:1'b0};
    vecs[3] = '{r:1'b1, e:1'b0, cv:1'b1, cs:2'd1, iv:1'b1, x_ready:1'b0, x_shift:1'b0,
                x_clr:1'b0, x_busy:1'b1, x_tap:2'd0, x_fill:7'd0, x_ov:1'b0};
    vecs[4] = '{r:1'b1, e:1'b1, cv:1'b0, cs:2'd0, iv:1'b0, x_ready:1'b1, x_shift:1'b0,
                x_clr:1'b0, x_busy:1'b1, x_tap:2'd0, x_fill:7'd0, x_ov:1'b0};

    rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_sel = 2'd0; in_valid = 1'b0; in_data = 8'd0;
    m_mode = M_IDLE; m_sel = 2'd0; m_fill = 0; m_out = 8'd0; m_ov = 1'b0; m_pend = 1'b0;
    m_pval = 8'd0;
    @(negedge clk);
    @(negedge clk);

    // reset, accept, one-cycle clear, ena freeze, FILL entry
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].cv, vecs[i].cs, vecs[i].iv, 8'd0);
      chk("vec_ready", 32'(pre_ready), 32'(vecs[i].x_ready));
      chk("vec_shift", 32'(pre_shift), 32'(vecs[i].x_shift));
      chk("vec_clr", 32'(pre_clr), 32'(vecs[i].x_clr));
      chk("vec_busy", 32'(busy), 32'(vecs[i].x_busy));
      chk("vec_tap", 32'(tap_sel), 32'(vecs[i].x_tap));
      chk("vec_fill", 32'(fill_cnt), 32'(vecs[i].x_fill));
      chk("vec_ov", 32'(out_valid), 32'(vecs[i].x_ov));
    end

    // tap 0 ramp: first valid output one clk after the 30th shift
    first = 0; first_val = 8'd0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(k));
      if (out_valid === 1'b1 && first == 0) begin
        first = k; first_val = out_data;
      end
    end
    chk("t1_first_step", 32'(first), 32'd31);
    chk("t1_first_data", 32'(first_val), 32'd1);

    // tap 3, half-duty input
    step(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int k = 0; k < 180; k++)
      step(1'b1, 1'b1, 1'b0, 2'd0, 1'(k % 2), 8'($urandom_range(1, 255)));
    chk("t2_fill", 32'(fill_cnt), 32'd90);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    chk("t2_ov_a", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'd33);
    chk("t2_ov_b", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    chk("t2_ov_c", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'd34);

    // tap change with a coincident sample in RUN
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'd77);
    chk("t3_acc_shift", 32'(pre_shift), 32'd0);
    chk("t3_tap", 32'(tap_sel), 32'd1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'd99);
    chk("t3_clr", 32'(pre_clr), 32'd1);
    first = 0; first_val = 8'd0;
    for (int k = 1; k <= 60; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(100 + k));
      if (out_valid === 1'b1 && first == 0) begin
        first = k; first_val = out_data;
      end
    end
    chk("t3_first_step", 32'(first), 32'd46);
    chk("t3_first_data", 32'(first_val), 32'd101);

    // ena low mid-FILL
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 20; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(k));
    chk("t4_fill20", 32'(fill_cnt), 32'd20);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 8'd200);
    chk("t4_ready", 32'(pre_ready), 32'd0);
    chk("t4_shift", 32'(pre_shift), 32'd0);
    chk("t4_hold", 32'(fill_cnt), 32'd20);
    for (int k = 21; k <= 60; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(k));
    chk("t4_fill60", 32'(fill_cnt), 32'd60);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    chk("t4_ov", 32'(out_valid), 32'd1);
    chk("t4_data", 32'(out_data), 32'd1);

    // reset mid-RUN
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd5);
    chk("t5_data", 32'(out_data), 32'd0);
    chk("t5_ov", 32'(out_valid), 32'd0);
    chk("t5_tap", 32'(tap_sel), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    chk("t5_ready", 32'(pre_ready), 32'd1);

    // out_data across a tap change
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 31; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(50 + k));
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    chk("t6_run_data", 32'(out_data), 32'd52);
    held = 8'd52;
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'(k + 1));
`ifdef DLY_CTRL_HOLD_EN
    chk("t6_hold", 32'(out_data), 32'(held));
`else
    chk("t6_zero", 32'(out_data), 32'd0);
`endif

    // randomized traffic against the reference model
    for (int k = 0; k < 2500; k++) begin
      step(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
